extbus_arbiter: RTL and testbench
=================================

EXTBUS_ARBITER -- requirements
Module: extbus_arbiter

Interface
REQ-001 Parameter TURN_CYC, default 1: tristate turnaround cycles between owners (legal 0..15).
REQ-002 Parameter MAX_HOLD, default 255: maximum consecutive granted cycles before forced release (legal 1..65535).
REQ-003 clk_bus  input  1  bus clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset; clears all state immediately on assertion, released synchronously with clk_bus.
REQ-005 usb_req  input  1  requester 0 (USB host controller) asks for the shared 16-bit data pins.
REQ-006 net_req  input  1  requester 1 (Ethernet controller) asks for the shared data pins.
REQ-007 usb_gnt  output  1  requester 0 owns the pins.
REQ-008 net_gnt  output  1  requester 1 owns the pins.
REQ-009 usb_data_o  input  8  requester 0 drive data.
REQ-010 usb_data_t  input  1  requester 0 tristate request (1 = release).
REQ-011 net_data_o  input  16  requester 1 drive data.
REQ-012 net_data_t  input  1  requester 1 tristate request (1 = release).
REQ-013 pad_data_o  output  16  value for the shared pins.
REQ-014 pad_data_t  output  1  pin tristate control (1 = high-Z).
REQ-015 hold_timeout  output  1  one-cycle pulse on forced release.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 State machine SHALL have states IDLE, OWN_USB, OWN_NET, TURN, encoded in registers.
REQ-018 In IDLE, a single asserted request SHALL move to the matching OWN state on the next edge; the grant is registered, so latency from req to gnt is exactly 1 cycle.
REQ-019 Both requests asserted in IDLE: grant the requester that was NOT the last owner (round-robin); the last-owner register resets to net, so usb wins the first tie.
REQ-020 In OWN_x, gnt_x SHALL stay high while req_x stays high and the hold count is below MAX_HOLD; the other requester is never granted in the same cycle. The two grants SHALL never be high together.
REQ-021 req_x deasserting in OWN_x: gnt_x drops on the next edge and the state becomes TURN (or IDLE if TURN_CYC=0).
REQ-022 Hold counter: 16 bits; cleared on entering OWN_x; increments each OWN_x cycle. When it reaches MAX_HOLD: gnt_x drops, hold_timeout pulses high for exactly 1 cycle, and the state goes to TURN (or IDLE if TURN_CYC=0).
REQ-023 After a forced release, requester x SHALL be masked (ignored) until it deasserts req_x for at least 1 cycle; the mask clears on req_x low or reset.
REQ-024 TURN SHALL last exactly TURN_CYC cycles, then go to IDLE; requests arriving during TURN are held pending and are not granted until IDLE evaluates them.
REQ-025 Last-owner register SHALL update on entry to OWN_x.
REQ-026 Pin mux, combinational from registered state:
- OWN_USB: pad_data_o = {8'h00, usb_data_o}, pad_data_t = usb_data_t.
- OWN_NET: pad_data_o = net_data_o, pad_data_t = net_data_t.
- IDLE and TURN: pad_data_o = 16'h0000, pad_data_t = 1.
REQ-027 A requester whose req is high but whose grant is low SHALL have no effect on the pins.
REQ-028 busy SHALL be 1 in OWN_USB, OWN_NET and TURN, and 0 in IDLE.

Reset
REQ-029 While rst_n=0:
- state = IDLE; usb_gnt = net_gnt = 0; hold_timeout = 0; busy = 0.
- pad_data_t = 1; pad_data_o = 0.
- hold counter = 0; turnaround counter = 0; masks cleared; last owner = net.
REQ-030 Reset asserted mid-grant SHALL drop the grant asynchronously, without a turnaround phase; after release the block starts in IDLE.

Verification
REQ-031 Single requester: usb_req=1 at cycle 0 -> usb_gnt=1 from cycle 1. With usb_data_o=8'hA5, usb_data_t=0: pad_data_o=16'h00A5, pad_data_t=0.
REQ-032 Tie and handoff: both reqs rise together after reset -> usb granted first. usb_req drops -> usb_gnt drops, 1 TURN cycle with pad_data_t=1, then net_gnt=1. Next tie -> usb granted (round-robin).
REQ-033 Timeout: MAX_HOLD=4, net_req held high -> net_gnt high for exactly 4 cycles, then hold_timeout pulses once. net is not re-granted until net_req goes low and then high again; a waiting usb_req is granted after TURN.
REQ-034 TURN_CYC=0: owner releases and the other request is pending -> new grant 1 cycle after release (one IDLE cycle), with no TURN state.
REQ-035 Reset mid-grant: rst_n low during OWN_NET -> net_gnt=0 and pad_data_t=1 in the same cycle, without waiting for a clock edge. After release, usb_req alone -> usb_gnt after 1 cycle.
REQ-036 Assertion checked every cycle: usb_gnt and net_gnt are never both 1, and pad_data_t=1 whenever neither grant is high.

Source files
------------

// File: rtl/extbus_arbiter.sv
// Two-requester arbiter for the shared 16-bit external data pins (USB host, Ethernet).
// Round-robin on ties, hold-time limit with forced release, and a tristate turnaround gap.
module extbus_arbiter #(
  parameter int unsigned TURN_CYC = 1,
  parameter int unsigned MAX_HOLD = 255
) (
  input  logic        clk_bus,
  input  logic        rst_n,
  input  logic        usb_req,
  input  logic        net_req,
  output logic        usb_gnt,
  output logic        net_gnt,
  input  logic [7:0]  usb_data_o,
  input  logic        usb_data_t,
  input  logic [15:0] net_data_o,
  input  logic        net_data_t,
  output logic [15:0] pad_data_o,
  output logic        pad_data_t,
  output logic        hold_timeout,
  output logic        busy
);

  localparam int unsigned HOLD_W = 16;
  localparam int unsigned TURN_W = 4;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned USB_W  = 8;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'((TURN_CYC == 0) ? 0 : TURN_CYC - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN_USB = 2'd1,
    OWN_NET = 2'd2,
    TURN    = 2'd3
  } state_e;

  // With no turnaround configured, a release goes straight back to IDLE.
  localparam state_e REL_STATE = (TURN_CYC == 0) ? IDLE : TURN;

  state_e              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [TURN_W-1:0]   turn_q, turn_d;
  logic                usb_mask_q, usb_mask_d;
  logic                net_mask_q, net_mask_d;
  logic                last_net_q, last_net_d;
  logic                usb_gnt_q, usb_gnt_d;
  logic                net_gnt_q, net_gnt_d;
  logic                timeout_q, timeout_d;
  logic                busy_q, busy_d;

  logic                usb_eff_c;
  logic                net_eff_c;
  logic                release_c;

  assign usb_eff_c = usb_req & ~usb_mask_q;
  assign net_eff_c = net_req & ~net_mask_q;

  // State and bookkeeping registers.
  always_ff @(posedge clk_bus or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      turn_q     <= '0;
      usb_mask_q <= 1'b0;
      net_mask_q <= 1'b0;
      last_net_q <= 1'b1;
      usb_gnt_q  <= 1'b0;
      net_gnt_q  <= 1'b0;
      timeout_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      turn_q     <= turn_d;
      usb_mask_q <= usb_mask_d;
      net_mask_q <= net_mask_d;
      last_net_q <= last_net_d;
      usb_gnt_q  <= usb_gnt_d;
      net_gnt_q  <= net_gnt_d;
      timeout_q  <= timeout_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state, hold/turn counters, masks and registered output values.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    turn_d     = turn_q;
    usb_mask_d = usb_mask_q & usb_req;
    net_mask_d = net_mask_q & net_req;
    last_net_d = last_net_q;
    timeout_d  = 1'b0;
    release_c  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (usb_eff_c && (!net_eff_c || last_net_q)) begin
          state_d    = OWN_USB;
          hold_d     = '0;
          last_net_d = 1'b0;
        end else if (net_eff_c) begin
          state_d    = OWN_NET;
          hold_d     = '0;
          last_net_d = 1'b1;
        end
      end
      OWN_USB: begin
        hold_d = hold_q + HOLD_W'(1);
        if (!usb_req) begin
          release_c = 1'b1;
        end else if (hold_q == HOLD_LAST) begin
          release_c  = 1'b1;
          timeout_d  = 1'b1;
          usb_mask_d = 1'b1;
        end
      end
      OWN_NET: begin
        hold_d = hold_q + HOLD_W'(1);
        if (!net_req) begin
          release_c = 1'b1;
        end else if (hold_q == HOLD_LAST) begin
          release_c  = 1'b1;
          timeout_d  = 1'b1;
          net_mask_d = 1'b1;
        end
      end
      TURN: begin
        if (turn_q == TURN_LAST) begin
          state_d = IDLE;
        end else begin
          turn_d = turn_q + TURN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (release_c) begin
      state_d = REL_STATE;
      turn_d  = '0;
    end

    usb_gnt_d = (state_d == OWN_USB);
    net_gnt_d = (state_d == OWN_NET);
    busy_d    = (state_d != IDLE);
  end

  // Pin mux follows the registered owner; a non-owner never reaches the pins.
  always_comb begin
    pad_data_o = '0;
    pad_data_t = 1'b1;
    unique case (state_q)
      OWN_USB: begin
        pad_data_o = {(DATA_W - USB_W)'(0), usb_data_o};
        pad_data_t = usb_data_t;
      end
      OWN_NET: begin
        pad_data_o = net_data_o;
        pad_data_t = net_data_t;
      end
      default: begin
        pad_data_o = '0;
        pad_data_t = 1'b1;
      end
    endcase
  end

  assign usb_gnt      = usb_gnt_q;
  assign net_gnt      = net_gnt_q;
  assign hold_timeout = timeout_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_extbus_arbiter.sv
// Directed bench for extbus_arbiter: instance a (TURN_CYC=1, MAX_HOLD=4) and
// instance b (TURN_CYC=0, MAX_HOLD=4) share all inputs.
module tb_extbus_arbiter;

  logic        clk_bus = 1'b0;
  logic        rst_n;
  logic        usb_req, net_req;
  logic [7:0]  usb_data_o;
  logic        usb_data_t;
  logic [15:0] net_data_o;
  logic        net_data_t;

  logic        a_usb_gnt, a_net_gnt, a_pad_data_t, a_hold_timeout, a_busy;
  logic [15:0] a_pad_data_o;
  logic        b_usb_gnt, b_net_gnt, b_pad_data_t, b_hold_timeout, b_busy;
  logic [15:0] b_pad_data_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_bus = ~clk_bus;

  extbus_arbiter #(.TURN_CYC(1), .MAX_HOLD(4)) dut_a (
    .clk_bus(clk_bus), .rst_n(rst_n),
    .usb_req(usb_req), .net_req(net_req),
    .usb_gnt(a_usb_gnt), .net_gnt(a_net_gnt),
    .usb_data_o(usb_data_o), .usb_data_t(usb_data_t),
    .net_data_o(net_data_o), .net_data_t(net_data_t),
    .pad_data_o(a_pad_data_o), .pad_data_t(a_pad_data_t),
    .hold_timeout(a_hold_timeout), .busy(a_busy)
  );

  extbus_arbiter #(.TURN_CYC(0), .MAX_HOLD(4)) dut_b (
    .clk_bus(clk_bus), .rst_n(rst_n),
    .usb_req(usb_req), .net_req(net_req),
    .usb_gnt(b_usb_gnt), .net_gnt(b_net_gnt),
    .usb_data_o(usb_data_o), .usb_data_t(usb_data_t),
    .net_data_o(net_data_o), .net_data_t(net_data_t),
    .pad_data_o(b_pad_data_o), .pad_data_t(b_pad_data_t),
    .hold_timeout(b_hold_timeout), .busy(b_busy)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_bus);
    #1;
  endtask

  task automatic expect_a(input string tag, input logic ug, input logic ng,
                          input logic pt, input logic bz, input logic to);
    check({tag, ".a_usb_gnt"}, 16'(a_usb_gnt), 16'(ug));
    check({tag, ".a_net_gnt"}, 16'(a_net_gnt), 16'(ng));
    check({tag, ".a_pad_t"},   16'(a_pad_data_t), 16'(pt));
    check({tag, ".a_busy"},    16'(a_busy), 16'(bz));
    check({tag, ".a_tmo"},     16'(a_hold_timeout), 16'(to));
  endtask

  task automatic expect_b(input string tag, input logic ug, input logic ng,
                          input logic pt, input logic bz, input logic to);
    check({tag, ".b_usb_gnt"}, 16'(b_usb_gnt), 16'(ug));
    check({tag, ".b_net_gnt"}, 16'(b_net_gnt), 16'(ng));
    check({tag, ".b_pad_t"},   16'(b_pad_data_t), 16'(pt));
    check({tag, ".b_busy"},    16'(b_busy), 16'(bz));
    check({tag, ".b_tmo"},     16'(b_hold_timeout), 16'(to));
  endtask

  // Every cycle: grants mutually exclusive, pins released when nobody owns them.
  always @(negedge clk_bus) begin
    check("mon.a_excl", 16'(a_usb_gnt & a_net_gnt), '0);
    check("mon.b_excl", 16'(b_usb_gnt & b_net_gnt), '0);
    if (!a_usb_gnt && !a_net_gnt) check("mon.a_idle_z", 16'(a_pad_data_t), 16'd1);
    if (!b_usb_gnt && !b_net_gnt) check("mon.b_idle_z", 16'(b_pad_data_t), 16'd1);
  end

  initial begin
    rst_n      = 1'b0;
    usb_req    = 1'b0;
    net_req    = 1'b0;
    usb_data_o = 8'hA5;
    usb_data_t = 1'b0;
    net_data_o = 16'hBEEF;
    net_data_t = 1'b0;
    step();
    step();

    // Reset state
    expect_a("rst", 0, 0, 1, 0, 0);
    expect_b("rst", 0, 0, 1, 0, 0);
    check("rst.a_pad_o", a_pad_data_o, '0);

    // Single requester, 1-cycle grant latency
    rst_n   = 1'b1;
    usb_req = 1'b1;
    #1;
    expect_a("usb.pre", 0, 0, 1, 0, 0);
    step();
    expect_a("usb.gnt", 1, 0, 0, 1, 0);
    check("usb.a_pad_o", a_pad_data_o, 16'h00A5);
    usb_data_t = 1'b1;
    #1;
    check("usb.a_pad_t_follow", 16'(a_pad_data_t), 16'd1);
    usb_data_t = 1'b0;
    usb_req    = 1'b0;
    step();
    expect_a("usb.turn", 0, 0, 1, 1, 0);
    check("usb.turn_pad_o", a_pad_data_o, '0);
    step();
    expect_a("usb.idle", 0, 0, 1, 0, 0);

    // Tie after reset: usb first, then handoff to net
    rst_n = 1'b0;
    #1;
    rst_n   = 1'b1;
    usb_req = 1'b1;
    net_req = 1'b1;
    step();
    expect_a("tie1", 1, 0, 0, 1, 0);
    expect_b("tie1", 1, 0, 0, 1, 0);
    check("tie1.a_pad_o", a_pad_data_o, 16'h00A5);
    usb_req = 1'b0;
    step();
    expect_a("hand.turn", 0, 0, 1, 1, 0);
    expect_b("hand.z_rel", 0, 0, 1, 0, 0);
    step();                                  // b enters OWN_NET here (E0)
    expect_a("hand.idle", 0, 0, 1, 0, 0);
    expect_b("hand.z_gnt", 0, 1, 0, 1, 0);
    check("hand.b_pad_o", b_pad_data_o, 16'hBEEF);
    step();                                  // E1: a enters OWN_NET
    expect_a("hand.net", 0, 1, 0, 1, 0);
    check("hand.a_pad_o", a_pad_data_o, 16'hBEEF);

    // Hold limit of 4 on net with usb waiting
    usb_req = 1'b1;
    step();                                  // E2
    expect_a("hold.2", 0, 1, 0, 1, 0);
    step();                                  // E3
    expect_a("hold.3", 0, 1, 0, 1, 0);
    expect_b("hold.z4", 0, 1, 0, 1, 0);
    step();                                  // E4
    expect_a("hold.4", 0, 1, 0, 1, 0);
    expect_b("hold.z_tmo", 0, 0, 1, 0, 1);
    step();                                  // E5
    expect_a("hold.tmo", 0, 0, 1, 1, 1);
    expect_b("hold.z_usb", 1, 0, 0, 1, 0);
    step();                                  // E6
    expect_a("hold.idle", 0, 0, 1, 0, 0);
    step();                                  // E7
    expect_a("hold.usb", 1, 0, 0, 1, 0);
    expect_b("hold.z_usb3", 1, 0, 0, 1, 0);
    usb_req = 1'b0;
    step();                                  // E8
    expect_a("mask.turn", 0, 0, 1, 1, 0);
    expect_b("mask.z_rel", 0, 0, 1, 0, 0);
    step();                                  // E9
    expect_a("mask.idle1", 0, 0, 1, 0, 0);
    expect_b("mask.z_idle1", 0, 0, 1, 0, 0);
    step();                                  // E10
    expect_a("mask.idle2", 0, 0, 1, 0, 0);
    expect_b("mask.z_idle2", 0, 0, 1, 0, 0);
    net_req = 1'b0;
    step();                                  // E11: mask clears
    expect_a("mask.drop", 0, 0, 1, 0, 0);
    net_req = 1'b1;
    step();                                  // E12
    expect_a("mask.regnt", 0, 1, 0, 1, 0);
    expect_b("mask.z_regnt", 0, 1, 0, 1, 0);

    // Requests arriving during TURN stay pending; round-robin tie goes to usb
    net_req = 1'b0;
    step();                                  // E13
    expect_a("rr.turn", 0, 0, 1, 1, 0);
    usb_req = 1'b1;
    net_req = 1'b1;
    step();                                  // E14
    expect_a("rr.pending", 0, 0, 1, 0, 0);
    expect_b("rr.z_tie", 1, 0, 0, 1, 0);
    step();                                  // E15
    expect_a("rr.tie", 1, 0, 0, 1, 0);
    usb_req = 1'b0;
    step();                                  // E16
    expect_a("rr.turn2", 0, 0, 1, 1, 0);
    step();                                  // E17
    expect_a("rr.idle2", 0, 0, 1, 0, 0);
    step();                                  // E18
    expect_a("rr.net", 0, 1, 0, 1, 0);
    expect_b("rr.z_net", 0, 1, 0, 1, 0);

    // Asynchronous reset mid-grant
    rst_n = 1'b0;
    #1;
    expect_a("arst", 0, 0, 1, 0, 0);
    expect_b("arst", 0, 0, 1, 0, 0);
    check("arst.a_pad_o", a_pad_data_o, '0);
    rst_n   = 1'b1;
    net_req = 1'b0;
    usb_req = 1'b1;
    step();
    expect_a("arst.usb", 1, 0, 0, 1, 0);
    expect_b("arst.usb", 1, 0, 0, 1, 0);
    usb_req = 1'b0;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
